// File: rtl/calc_sequencer.sv
// Calculator control FSM: keypad strobes -> operand-buffer/ALU control pulses, ALU wait with timeout.
// Latency: every output is registered, one cycle after the sampled strobe; no backpressure, strobes ignored while busy are dropped.
module calc_sequencer #(
  parameter int ALU_TIMEOUT = 16,
  parameter int OPW         = 2
) (
  input  logic           clk,
  input  logic           nrst,
  input  logic           digit_strobe,
  input  logic           op_strobe,
  input  logic [OPW-1:0] op_code,
  input  logic           equals_strobe,
  input  logic           clear_strobe,
  input  logic           alu_done,
  input  logic           alu_overflow,
  output logic           store_digit,
  output logic           enter,
  output logic           load_a,
  output logic           a_src,
  output logic           load_b,
  output logic           alu_start,
  output logic [OPW-1:0] alu_op,
  output logic           result_ready,
  output logic           busy,
  output logic           error,
  output logic [2:0]     state
);

  typedef enum logic [2:0] {
    ENTRY_A  = 3'd0,
    ENTRY_B  = 3'd1,
    LAUNCH   = 3'd2,
    WAIT_ALU = 3'd3,
    SHOW     = 3'd4,
    ERROR    = 3'd5
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(ALU_TIMEOUT - 1);

  state_t     st;
  logic [7:0] cnt;

  assign state = st;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      st           <= ENTRY_A;
      cnt          <= 8'd0;
      store_digit  <= 1'b0;
      enter        <= 1'b0;
      load_a       <= 1'b0;
      a_src        <= 1'b0;
      load_b       <= 1'b0;
      alu_start    <= 1'b0;
      alu_op       <= '0;
      result_ready <= 1'b0;
      busy         <= 1'b0;
      error        <= 1'b0;
    end else begin
      store_digit  <= 1'b0;
      enter        <= 1'b0;
      load_a       <= 1'b0;
      load_b       <= 1'b0;
      alu_start    <= 1'b0;
      result_ready <= 1'b0;

      if (clear_strobe) begin
        enter  <= 1'b1;
        st     <= ENTRY_A;
        alu_op <= '0;
        a_src  <= 1'b0;
        error  <= 1'b0;
        busy   <= 1'b0;
        cnt    <= 8'd0;
      end else begin
        case (st)
          ENTRY_A: begin
            // equals outranks op/digit here even though it does nothing
            if (equals_strobe) begin
            end else if (op_strobe) begin
              load_a <= 1'b1;
              a_src  <= 1'b0;
              enter  <= 1'b1;
              alu_op <= op_code;
              st     <= ENTRY_B;
            end else if (digit_strobe) begin
              store_digit <= 1'b1;
            end
          end
          ENTRY_B: begin
            if (equals_strobe) begin
              load_b <= 1'b1;
              busy   <= 1'b1;
              st     <= LAUNCH;
            end else if (op_strobe) begin
              alu_op <= op_code;
            end else if (digit_strobe) begin
              store_digit <= 1'b1;
            end
          end
          LAUNCH: begin
            alu_start <= 1'b1;
            cnt       <= 8'd0;
            st        <= WAIT_ALU;
          end
          WAIT_ALU: begin
            if (alu_done) begin
              result_ready <= 1'b1;
              busy         <= 1'b0;
              if (alu_overflow) begin
                error <= 1'b1;
                st    <= ERROR;
              end else begin
                st <= SHOW;
              end
            end else if (cnt >= CNT_LAST) begin
              error <= 1'b1;
              busy  <= 1'b0;
              st    <= ERROR;
            end else if (cnt != 8'hFF) begin
              cnt <= cnt + 8'd1;
            end
          end
          SHOW: begin
            if (equals_strobe) begin
            end else if (op_strobe) begin
              // chain: previous result becomes operand A
              load_a <= 1'b1;
              a_src  <= 1'b1;
              enter  <= 1'b1;
              alu_op <= op_code;
              st     <= ENTRY_B;
            end else if (digit_strobe) begin
              store_digit <= 1'b1;
              a_src       <= 1'b0;
              st          <= ENTRY_A;
            end
          end
          ERROR: begin
          end
          default: begin
            st <= ENTRY_A;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: key sequences with hand-computed pulse/state expectations.
module tb_calc_sequencer;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       digit_strobe = 1'b0;
  logic       op_strobe = 1'b0;
  logic [1:0] op_code = 2'd0;
  logic       equals_strobe = 1'b0;
  logic       clear_strobe = 1'b0;
  logic       alu_done = 1'b0;
  logic       alu_overflow = 1'b0;
  logic       store_digit, enter, load_a, a_src, load_b, alu_start;
  logic [1:0] alu_op;
  logic       result_ready, busy, error;
  logic [2:0] state;

  int total = 0;
  int bad = 0;

  // {store_digit, enter, load_a, load_b, alu_start, result_ready, state, error, busy}
  logic [10:0] snap;
  assign snap = {store_digit, enter, load_a, load_b, alu_start, result_ready, state, error, busy};

  calc_sequencer #(.ALU_TIMEOUT(16), .OPW(2)) dut (
    .clk(clk), .nrst(nrst),
    .digit_strobe(digit_strobe), .op_strobe(op_strobe), .op_code(op_code),
    .equals_strobe(equals_strobe), .clear_strobe(clear_strobe),
    .alu_done(alu_done), .alu_overflow(alu_overflow),
    .store_digit(store_digit), .enter(enter), .load_a(load_a), .a_src(a_src),
    .load_b(load_b), .alu_start(alu_start), .alu_op(alu_op),
    .result_ready(result_ready), .busy(busy), .error(error), .state(state)
  );

  always #5 clk = ~clk;

  task tick();
    @(posedge clk);
    #1;
  endtask

  task key(input logic d, input logic o, input logic e, input logic c, input logic [1:0] code);
    digit_strobe  = d;
    op_strobe     = o;
    equals_strobe = e;
    clear_strobe  = c;
    op_code       = code;
    tick();
    digit_strobe  = 1'b0;
    op_strobe     = 1'b0;
    equals_strobe = 1'b0;
    clear_strobe  = 1'b0;
    op_code       = 2'd0;
  endtask

  task test_reset();
    nrst = 1'b0;
    #12;
    total++; if (snap !== 11'b000000_000_0_0) begin bad++; $display("FAIL reset_snap got=%b want=%b", snap, 11'b000000_000_0_0); end
    total++; if ({alu_op, a_src} !== 3'b000) begin bad++; $display("FAIL reset_op_src got=%b want=%b", {alu_op, a_src}, 3'b000); end
    nrst = 1'b1;
    tick();
  endtask

  task test_basic();
    key(1, 0, 0, 0, 2'd0);
    total++; if (snap !== 11'b100000_000_0_0) begin bad++; $display("FAIL basic_digit got=%b want=%b", snap, 11'b100000_000_0_0); end
    key(0, 1, 0, 0, 2'd2);
    total++; if (snap !== 11'b011000_001_0_0) begin bad++; $display("FAIL basic_op got=%b want=%b", snap, 11'b011000_001_0_0); end
    total++; if ({alu_op, a_src} !== 3'b100) begin bad++; $display("FAIL basic_op_src got=%b want=%b", {alu_op, a_src}, 3'b100); end
    key(1, 0, 0, 0, 2'd0);
    total++; if (snap !== 11'b100000_001_0_0) begin bad++; $display("FAIL basic_digit_b got=%b want=%b", snap, 11'b100000_001_0_0); end
    key(0, 0, 1, 0, 2'd0);
    total++; if (snap !== 11'b000100_010_0_1) begin bad++; $display("FAIL basic_equals got=%b want=%b", snap, 11'b000100_010_0_1); end
    tick();
    total++; if (snap !== 11'b000010_011_0_1) begin bad++; $display("FAIL basic_start got=%b want=%b", snap, 11'b000010_011_0_1); end
    tick(); tick(); tick();
    total++; if (snap !== 11'b000000_011_0_1) begin bad++; $display("FAIL basic_wait got=%b want=%b", snap, 11'b000000_011_0_1); end
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    total++; if (snap !== 11'b000001_100_0_0) begin bad++; $display("FAIL basic_result got=%b want=%b", snap, 11'b000001_100_0_0); end
  endtask

  task test_chain();
    key(0, 1, 0, 0, 2'd1);
    total++; if (snap !== 11'b011000_001_0_0) begin bad++; $display("FAIL chain_op got=%b want=%b", snap, 11'b011000_001_0_0); end
    total++; if ({alu_op, a_src} !== 3'b011) begin bad++; $display("FAIL chain_op_src got=%b want=%b", {alu_op, a_src}, 3'b011); end
    key(0, 1, 0, 0, 2'd3);
    total++; if ({snap, alu_op} !== {11'b000000_001_0_0, 2'd3}) begin bad++; $display("FAIL chain_replace got=%b want=%b", {snap, alu_op}, {11'b000000_001_0_0, 2'd3}); end
    key(1, 0, 0, 0, 2'd0);
    key(0, 1, 1, 0, 2'd2);
    total++; if ({snap, alu_op} !== {11'b000100_010_0_1, 2'd3}) begin bad++; $display("FAIL chain_eq_over_op got=%b want=%b", {snap, alu_op}, {11'b000100_010_0_1, 2'd3}); end
    tick();
    total++; if ({snap, alu_op, a_src} !== {11'b000010_011_0_1, 2'd3, 1'b1}) begin bad++; $display("FAIL chain_start got=%b want=%b", {snap, alu_op, a_src}, {11'b000010_011_0_1, 2'd3, 1'b1}); end
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    total++; if (snap !== 11'b000001_100_0_0) begin bad++; $display("FAIL chain_result got=%b want=%b", snap, 11'b000001_100_0_0); end
    key(1, 0, 0, 0, 2'd0);
    total++; if ({snap, a_src} !== {11'b100000_000_0_0, 1'b0}) begin bad++; $display("FAIL show_digit got=%b want=%b", {snap, a_src}, {11'b100000_000_0_0, 1'b0}); end
  endtask

  task test_timeout();
    key(0, 1, 0, 0, 2'd0);
    key(0, 0, 1, 0, 2'd0);
    tick();
    total++; if (snap !== 11'b000010_011_0_1) begin bad++; $display("FAIL to_start got=%b want=%b", snap, 11'b000010_011_0_1); end
    for (int k = 1; k <= 15; k++) tick();
    total++; if (snap !== 11'b000000_011_0_1) begin bad++; $display("FAIL to_cycle15 got=%b want=%b", snap, 11'b000000_011_0_1); end
    tick();
    total++; if (snap !== 11'b000000_101_1_0) begin bad++; $display("FAIL to_cycle16 got=%b want=%b", snap, 11'b000000_101_1_0); end
    key(1, 0, 0, 0, 2'd0);
    key(0, 1, 0, 0, 2'd1);
    alu_done = 1'b1;
    key(0, 0, 1, 0, 2'd0);
    alu_done = 1'b0;
    total++; if (snap !== 11'b000000_101_1_0) begin bad++; $display("FAIL err_ignores got=%b want=%b", snap, 11'b000000_101_1_0); end
    key(0, 0, 0, 1, 2'd0);
    total++; if ({snap, alu_op} !== {11'b010000_000_0_0, 2'd0}) begin bad++; $display("FAIL err_clear got=%b want=%b", {snap, alu_op}, {11'b010000_000_0_0, 2'd0}); end
  endtask

  task test_overflow();
    key(0, 1, 0, 0, 2'd3);
    key(0, 0, 1, 0, 2'd0);
    tick();
    alu_done = 1'b1;
    alu_overflow = 1'b1;
    tick();
    alu_done = 1'b0;
    alu_overflow = 1'b0;
    total++; if (snap !== 11'b000001_101_1_0) begin bad++; $display("FAIL ovf_result got=%b want=%b", snap, 11'b000001_101_1_0); end
    key(1, 0, 0, 0, 2'd0);
    total++; if (snap !== 11'b000000_101_1_0) begin bad++; $display("FAIL ovf_digit got=%b want=%b", snap, 11'b000000_101_1_0); end
    key(0, 0, 0, 1, 2'd0);
  endtask

  task test_clear_priority();
    key(0, 1, 0, 0, 2'd2);
    key(1, 0, 0, 1, 2'd0);
    total++; if ({snap, alu_op} !== {11'b010000_000_0_0, 2'd0}) begin bad++; $display("FAIL clr_digit got=%b want=%b", {snap, alu_op}, {11'b010000_000_0_0, 2'd0}); end
  endtask

  task test_abort();
    key(0, 1, 0, 0, 2'd1);
    key(0, 0, 1, 0, 2'd0);
    tick();
    tick();
    key(0, 0, 0, 1, 2'd0);
    total++; if (snap !== 11'b010000_000_0_0) begin bad++; $display("FAIL abort_clear got=%b want=%b", snap, 11'b010000_000_0_0); end
    tick();
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    total++; if (snap !== 11'b000000_000_0_0) begin bad++; $display("FAIL abort_late_done got=%b want=%b", snap, 11'b000000_000_0_0); end
  endtask

  task test_async_reset();
    key(0, 1, 0, 0, 2'd2);
    key(0, 0, 1, 0, 2'd0);
    tick();
    tick();
    total++; if (snap !== 11'b000000_011_0_1) begin bad++; $display("FAIL arst_pre got=%b want=%b", snap, 11'b000000_011_0_1); end
    #2 nrst = 1'b0;
    #1;
    total++; if ({snap, alu_op, a_src} !== 14'd0) begin bad++; $display("FAIL arst_mid got=%b want=%b", {snap, alu_op, a_src}, 14'd0); end
    #2 nrst = 1'b1;
    tick();
    total++; if (snap !== 11'b000000_000_0_0) begin bad++; $display("FAIL arst_after got=%b want=%b", snap, 11'b000000_000_0_0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_chain();
    test_timeout();
    test_overflow();
    test_clear_priority();
    test_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Control FSM that sequences the operand buffer and the ALU for the calculator datapath. It turns keypad event strobes (digit, operator, equals, clear) into one-cycle control pulses: store_digit and enter to the operand buffer, load_a and load_b to the operand registers, and alu_start to the ALU. It waits for ALU completion with a timeout, then hands the result to the display path via result_ready and tracks the error condition.

Parameters:
ALU_TIMEOUT, 16, max cycles in WAIT_ALU (counted from the alu_start cycle) before forcing ERROR; legal range 2..255.
OPW, 2, width of operator code.

Ports:
clk  input  1  system clock
nrst  input  1  asynchronous active-low reset
digit_strobe  input  1  one-cycle pulse: digit key decoded
op_strobe  input  1  one-cycle pulse: operator key decoded
op_code  input  OPW  operator code, valid with op_strobe
equals_strobe  input  1  one-cycle pulse: equals key
clear_strobe  input  1  one-cycle pulse: clear key
alu_done  input  1  ALU result valid, sampled only in WAIT_ALU
alu_overflow  input  1  ALU overflow, valid with alu_done
store_digit  output  1  pulse to operand buffer: latch digit
enter  output  1  pulse to operand buffer: clear operand/display
load_a  output  1  pulse: capture operand A
a_src  output  1  A source: 0 = operand buffer, 1 = previous result; held until next load_a
load_b  output  1  pulse: capture operand B from operand buffer
alu_start  output  1  pulse: start ALU
alu_op  output  OPW  latched operator, stable from load_a through WAIT_ALU
result_ready  output  1  pulse: ALU result to display
busy  output  1  high in LAUNCH and WAIT_ALU
error  output  1  high in ERROR
state  output  3  encoded state for debug: ENTRY_A=0, ENTRY_B=1, LAUNCH=2, WAIT_ALU=3, SHOW=4, ERROR=5

Behaviour:
- All outputs registered. Each pulse is high for exactly one cycle: the cycle after the triggering strobe is sampled.
- Reset (async, nrst low): state=ENTRY_A; all pulses 0; alu_op=0; a_src=0; error=0; busy=0; timeout counter=0.
- Strobe priority in the same cycle: clear > equals > op > digit. Lower-priority strobes are dropped.
- clear_strobe, any state: enter=1; state→ENTRY_A; alu_op=0; a_src=0; error=0; counter=0. Aborts LAUNCH/WAIT_ALU; a late alu_done is ignored.
- ENTRY_A:
  - digit → store_digit.
  - op → load_a=1, a_src=0, enter=1, alu_op=op_code, →ENTRY_B.
  - equals → ignored.
- ENTRY_B:
  - digit → store_digit.
  - op → alu_op=op_code (operator replace); no pulses; stay.
  - equals → load_b=1, →LAUNCH.
- LAUNCH: unconditionally alu_start=1, counter=0, →WAIT_ALU. Key strobes other than clear are ignored.
- WAIT_ALU:
  - alu_done=1 → result_ready=1; →ERROR if alu_overflow, else →SHOW.
  - Otherwise counter+1. Reaching ALU_TIMEOUT-1 without done → ERROR, result_ready=0.
  - alu_done arriving on the same cycle as the timeout wins.
  - Key strobes other than clear are ignored.
- SHOW:
  - digit → store_digit, a_src=0, →ENTRY_A (new calculation).
  - op → chaining: load_a=1, a_src=1, enter=1, alu_op=op_code, →ENTRY_B.
  - equals → ignored.
- ERROR: error=1; only clear is accepted.
- alu_done outside WAIT_ALU: ignored, no state effect.
- Counter is 8 bits and saturates; it never wraps.

Test Plan:
- Reset, then digit, op(code=2), digit, equals; alu_done 3 cycles after alu_start with overflow=0 → store_digit, then load_a+enter with alu_op=2, then store_digit, then load_b, next cycle alu_start, then result_ready 1 cycle after done; state=4.
- Equals in ENTRY_B, alu_done never asserted, ALU_TIMEOUT=16 → state=5 and error=1, reached 16 cycles after alu_start; result_ready stays 0. Then clear → enter, state=0, error=0.
- alu_done with alu_overflow=1 → result_ready=1 and state=5. Digit/op/equals while in ERROR → no pulses.
- In SHOW, op(code=1) → load_a=1, a_src=1, enter=1, alu_op=1, state=1. Then digit and equals → full second operation with a_src held at 1.
- clear_strobe and digit_strobe in the same cycle in ENTRY_B → enter only, no store_digit, state=0.
- Clear during WAIT_ALU, then alu_done 2 cycles later → no result_ready, state=0. Assert nrst low mid-WAIT_ALU → all outputs return to reset values immediately.
